// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// ------------------
// Write-back arbiter for the 64-entry register file.
//
// The register file has one write port. This block shares that port among
// NumReq producers (ALU, load unit, multiplier, ...). Each cycle it grants
// at most one producer through a valid/ready handshake. It then captures
// the granted address and data into the output register that drives the
// file's write port.
//
// Build option:
//   REGFILE_WB_FIXED_PRIORITY_EN - when defined, the round-robin pointer is
//   removed. The scan always starts at requester 0, so the lowest index wins.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous, active-low reset
//   req_valid      per-requester write pending
//   req_addr       packed per-requester addresses, [i*AddrWidth +: AddrWidth]
//   req_data       packed per-requester data, [i*DataLength +: DataLength]
//   req_ready      combinational one-hot grant (all zero when nothing granted)
//   wb_hold        suppresses all grants this cycle
//   RegWrite       registered write enable to the register file
//   writereg_addr  registered write address
//   write_data     registered write data
//   wb_conflict    registered pulse: previous cycle granted with >=2 valid
module regfile_wb_arbiter #(
  parameter int DataLength = 64,
  parameter int NumReq     = 3,
  parameter int AddrWidth  = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NumReq-1:0]            req_valid,
  input  logic [NumReq*AddrWidth-1:0]  req_addr,
  input  logic [NumReq*DataLength-1:0] req_data,
  output logic [NumReq-1:0]            req_ready,
  input  logic                         wb_hold,
  output logic                         RegWrite,
  output logic [AddrWidth-1:0]         writereg_addr,
  output logic [DataLength-1:0]        write_data,
  output logic                         wb_conflict
);

  localparam int PtrW = $clog2(NumReq);

  // Scan start point for this cycle.
  logic [PtrW-1:0] scan_start;

`ifdef REGFILE_WB_FIXED_PRIORITY_EN
  assign scan_start = '0;
`else
  logic [PtrW-1:0] rr_ptr_reg;
  logic [PtrW-1:0] rr_ptr_next;

  assign scan_start = rr_ptr_reg;
`endif

  // scan_idx[k] is the k-th requester examined in this cycle:
  // (scan_start + k) mod NumReq.
  // The sum never reaches 2*NumReq, so one conditional subtract is enough.
  logic [31:0]     scan_sum [NumReq];
  logic [PtrW-1:0] scan_idx [NumReq];

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_scan
      assign scan_sum[gi] = {{(32-PtrW){1'b0}}, scan_start} + 32'(gi);
      assign scan_idx[gi] = (scan_sum[gi] >= 32'(NumReq))
                          ? PtrW'(scan_sum[gi] - 32'(NumReq))
                          : PtrW'(scan_sum[gi]);
    end
  endgenerate

  // Grant selection. The first valid requester in scan order wins.
  // Reset and hold force the grant off, so the one-hot ready vector is
  // only ever set for a requester that is valid.
  logic            grant_found;
  logic [PtrW-1:0] grant_idx;
  logic [NumReq-1:0] ready_vec;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    ready_vec   = '0;
    if (rst_n && !wb_hold) begin
      for (int k = 0; k < NumReq; k++) begin
        if (!grant_found && req_valid[scan_idx[k]]) begin
          grant_found = 1'b1;
          grant_idx   = scan_idx[k];
        end
      end
    end
    if (grant_found) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  assign req_ready = ready_vec;

  // Payload of the granted requester.
  logic [AddrWidth-1:0]  grant_addr;
  logic [DataLength-1:0] grant_data;

  assign grant_addr = req_addr[int'(grant_idx)*AddrWidth +: AddrWidth];
  assign grant_data = req_data[int'(grant_idx)*DataLength +: DataLength];

  // A conflict is a granted cycle in which another requester also had to
  // wait. NumReq is at most 4, so a 3-bit count is enough.
  logic [2:0] valid_cnt;
  logic       conflict_next;

  always_comb begin
    valid_cnt = '0;
    for (int k = 0; k < NumReq; k++) begin
      valid_cnt = valid_cnt + {2'b00, req_valid[k]};
    end
    conflict_next = grant_found && (valid_cnt >= 3'd2);
  end

`ifndef REGFILE_WB_FIXED_PRIORITY_EN
  // After a grant, the pointer moves just past the winner.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_found) begin
      rr_ptr_next = (grant_idx == PtrW'(NumReq - 1)) ? '0
                                                     : grant_idx + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`endif

  // Output register. Address and data hold their previous values when
  // there is no transfer, so only the enable needs to drop.
  logic                  reg_write_reg;
  logic [AddrWidth-1:0]  addr_reg;
  logic [DataLength-1:0] data_reg;
  logic                  conflict_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_reg <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      conflict_reg  <= 1'b0;
    end else begin
      reg_write_reg <= grant_found;
      conflict_reg  <= conflict_next;
      if (grant_found) begin
        addr_reg <= grant_addr;
        data_reg <= grant_data;
      end
    end
  end

  assign RegWrite      = reg_write_reg;
  assign writereg_addr = addr_reg;
  assign write_data    = data_reg;
  assign wb_conflict   = conflict_reg;

endmodule
